// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS definitions: checker states and LFSR step function
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    localparam int LFSR_MAX_W = 64;

    // Callers zero-extend state/taps and truncate the result back to their own width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] x,
        input logic [LFSR_MAX_W-1:0] poly
    );
        logic [LFSR_MAX_W-1:0] tapped;
        logic                  fb;
        tapped = x & poly;
        fb     = ^tapped;
        return {x[LFSR_MAX_W-2:0], fb};
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// rtl/prbs_checker_if.sv - received LFSR word stream into the checker
interface prbs_checker_if #(
    parameter int DATA_WIDTH = 4
) ();
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data);
    modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/prbs_sat_counter.sv
// rtl/prbs_sat_counter.sv - saturating statistics counter with synchronous clear
module prbs_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising LFSR stream checker with lock and error statistics
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 4,
    parameter logic [DATA_WIDTH-1:0] POLYNOMIAL   = 4'h9,
    parameter int                    LOCK_COUNT   = 4,
    parameter int                    UNLOCK_COUNT = 3,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    prbs_checker_if.slave        rx,
    input  logic                 clear,
    output logic                 locked,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int UCW = $clog2(UNLOCK_COUNT + 1);

    prbs_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [MCW-1:0]        match_q, match_d;
    logic [UCW-1:0]        miss_q, miss_d;
    logic                  error_q, error_d;
    logic                  word_inc, err_inc;
    logic [DATA_WIDTH-1:0] next_in, next_exp;
    logic                  hit, in_zero;

    assign next_in  = DATA_WIDTH'(lfsr_next(LFSR_MAX_W'(rx.in_data), LFSR_MAX_W'(POLYNOMIAL)));
    assign next_exp = DATA_WIDTH'(lfsr_next(LFSR_MAX_W'(exp_q), LFSR_MAX_W'(POLYNOMIAL)));
    assign hit      = (rx.in_data == exp_q);
    assign in_zero  = (rx.in_data == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            exp_q   <= '0;
            match_q <= '0;
            miss_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        match_d  = match_q;
        miss_d   = miss_q;
        error_d  = 1'b0;
        word_inc = 1'b0;
        err_inc  = 1'b0;
        if (rx.in_valid) begin
            case (state_q)
                IDLE: begin
                    // All-zero is the LFSR lockup word and cannot seed a sequence.
                    if (!in_zero) begin
                        exp_d   = next_in;
                        match_d = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    exp_d = next_in;
                    if (hit) begin
                        match_d = match_q + MCW'(1);
                        if (match_q == MCW'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                        if (in_zero) state_d = IDLE;
                    end
                end
                LOCKED: begin
                    word_inc = 1'b1;
                    // Flywheel on our own prediction so a corrupted word is not propagated.
                    exp_d    = next_exp;
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        error_d = 1'b1;
                        err_inc = 1'b1;
                        miss_d  = miss_q + UCW'(1);
                        if (miss_q == UCW'(UNLOCK_COUNT - 1)) begin
                            exp_d   = next_in;
                            match_d = '0;
                            state_d = in_zero ? IDLE : SYNC;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign locked = (state_q == LOCKED);
    assign error  = error_q;

    prbs_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clear (clear),
        .count (err_count)
    );

    prbs_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_word_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (word_inc),
        .clear (clear),
        .count (word_count)
    );

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed and randomized checks of prbs_checker against a behavioural model
module tb_prbs_checker;

    localparam int W      = 4;
    localparam int POLY   = 9;
    localparam int LOCK   = 4;
    localparam int UNLOCK = 3;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          locked;
    logic          error;
    logic [CW-1:0] err_count;
    logic [CW-1:0] word_count;

    prbs_checker_if #(.DATA_WIDTH(W)) bus ();

    prbs_checker #(
        .DATA_WIDTH   (W),
        .POLYNOMIAL   (4'h9),
        .LOCK_COUNT   (LOCK),
        .UNLOCK_COUNT (UNLOCK),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (bus),
        .clear      (clear),
        .locked     (locked),
        .error      (error),
        .err_count  (err_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: 0 = idle, 1 = sync, 2 = locked
    int m_state, m_exp, m_match, m_miss, m_err, m_words;
    int m_error;
    int g;

    function automatic int nxt(input int x);
        int fb = 0;
        for (int i = 0; i < W; i++)
            if ((((x >> i) & 1) == 1) && (((POLY >> i) & 1) == 1)) fb = fb ^ 1;
        return ((x * 2) + fb) % (1 << W);
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    function automatic logic [W-1:0] bad_word();
        int b;
        b = m_exp ^ 1;
        if (b == 0) b = 3;
        return W'(b);
    endfunction

    task automatic model_reset();
        m_state = 0; m_exp = 0; m_match = 0; m_miss = 0;
        m_err = 0; m_words = 0; m_error = 0;
    endtask

    task automatic model(input bit v, input int d, input bit c);
        m_error = 0;
        if (v) begin
            if (m_state == 0) begin
                if (d != 0) begin m_exp = nxt(d); m_match = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (d == m_exp) begin
                    m_match++;
                    if (m_match == LOCK) begin m_state = 2; m_miss = 0; end
                end else begin
                    m_match = 0;
                    if (d == 0) m_state = 0;
                end
                m_exp = nxt(d);
            end else begin
                m_words = sat_inc(m_words);
                if (d == m_exp) begin
                    m_miss = 0;
                    m_exp  = nxt(m_exp);
                end else begin
                    m_error = 1;
                    m_err   = sat_inc(m_err);
                    m_miss++;
                    if (m_miss == UNLOCK) begin
                        m_state = (d == 0) ? 0 : 1;
                        m_exp   = nxt(d);
                        m_match = 0;
                    end else begin
                        m_exp = nxt(m_exp);
                    end
                end
            end
        end
        if (c) begin m_err = 0; m_words = 0; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"},     32'(locked),         32'(m_state == 2));
        chk({tag, ".error"},      32'(error),          32'(m_error));
        chk({tag, ".err_count"},  32'(err_count),      32'(m_err));
        chk({tag, ".word_count"}, 32'(word_count),     32'(m_words));
        chk({tag, ".state"},      32'(int'(dut.state_q)), 32'(m_state));
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit c);
        bus.in_valid = v;
        bus.in_data  = d;
        clear        = c;
        @(posedge clk);
        model(v, int'(d), c);
        #1;
        check_all("step");
        bus.in_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic feed_good(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, W'(g), 1'b0);
            g = nxt(g);
        end
    endtask

    task automatic feed_bad(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, bad_word(), 1'b0);
            g = nxt(g);
        end
    endtask

    initial begin
        reset        = 1'b1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();
        chk("reset.locked", 32'(locked), 0);
        chk("reset.error", 32'(error), 0);
        chk("reset.err_count", 32'(err_count), 0);
        chk("reset.word_count", 32'(word_count), 0);
        chk("reset.state", 32'(int'(dut.state_q)), 0);

        // Acquire lock from 0001; locked rises one cycle after the fifth word.
        g = 1;
        feed_good(4);
        chk("lock.before", 32'(locked), 0);
        feed_good(1);
        chk("lock.after", 32'(locked), 1);
        feed_good(3);
        chk("lock.word_count", 32'(word_count), 3);
        chk("lock.err_count", 32'(err_count), 0);

        // Single corruption while locked; flywheel keeps later words matching.
        feed_bad(1);
        chk("corrupt.error", 32'(error), 1);
        chk("corrupt.err_count", 32'(err_count), 1);
        chk("corrupt.locked", 32'(locked), 1);
        feed_good(2);
        chk("corrupt.error_low", 32'(error), 0);
        chk("corrupt.word_count", 32'(word_count), 6);
        chk("corrupt.err_hold", 32'(err_count), 1);

        // Loss of lock after three consecutive mismatches, then relock.
        feed_bad(2);
        chk("unlock.still_locked", 32'(locked), 1);
        feed_bad(1);
        chk("unlock.locked", 32'(locked), 0);
        chk("unlock.err_count", 32'(err_count), 4);
        chk("unlock.state", 32'(int'(dut.state_q)), 1);
        feed_good(5);
        chk("relock.locked", 32'(locked), 1);

        // Zero words in IDLE are ignored; gapped stream still locks.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0);
        chk("zero.state", 32'(int'(dut.state_q)), 0);
        g = 1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, W'(g), 1'b0);
            g = nxt(g);
            if (i == 4) chk("gaps.locked", 32'(locked), 1);
            step(1'b0, W'($urandom_range(0, 15)), 1'b0);
        end
        chk("gaps.held", 32'(locked), 1);

        // Saturation of err_count across repeated unlock/relock cycles.
        for (int r = 0; r < 6; r++) begin
            feed_bad(UNLOCK);
            step(1'b1, '0, 1'b0);
            g = 1;
            feed_good(5);
        end
        chk("sat.err_count", 32'(err_count), CMAX);
        chk("sat.locked", 32'(locked), 1);
        bus.in_valid = 1'b1;
        step(1'b1, bad_word(), 1'b1);
        g = nxt(g);
        chk("clear.err_count", 32'(err_count), 0);
        chk("clear.word_count", 32'(word_count), 0);
        chk("clear.locked", 32'(locked), 1);

        // Reset together with clear while locked.
        reset        = 1'b1;
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = W'(g);
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0; clear = 1'b0; bus.in_valid = 1'b0;
        chk("rst_mid.locked", 32'(locked), 0);
        chk("rst_mid.error", 32'(error), 0);
        chk("rst_mid.err_count", 32'(err_count), 0);
        chk("rst_mid.word_count", 32'(word_count), 0);
        chk("rst_mid.state", 32'(int'(dut.state_q)), 0);

        // Randomized stream: gaps, corruptions, zero words and clears.
        g = $urandom_range(1, 15);
        for (int i = 0; i < 600; i++) begin
            bit          v, c;
            logic [W-1:0] d;
            int           sel;
            v   = ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 39) == 0);
            sel = $urandom_range(0, 19);
            d   = W'(g);
            if (sel == 0) d = '0;
            else if (sel < 4) d = W'($urandom_range(0, 15));
            step(v, d, c);
            if (v) g = nxt(g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the team's LFSR pattern generator: consumes a stream of parallel LFSR state words and checks each against the next state predicted from the same polynomial.
- Self-synchronising: seeds from the incoming stream, acquires lock, then flywheels on its own prediction and counts mismatching words.
- Sits at the far end of a datapath under test (DMA loopback, memory BIST, link test) and reports lock and error statistics to a CSR block.

Parameters:
- DATA_WIDTH, 4, LFSR state width (>= 2).
- POLYNOMIAL, 4'h9, tap mask, DATA_WIDTH bits, identical to the generator's.
- LOCK_COUNT, 4, consecutive matching words in SYNC needed to declare lock (>= 1).
- UNLOCK_COUNT, 3, consecutive mismatching words in LOCKED that drop lock (>= 1).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_data qualifier; one word checked per cycle when high.
- in_data  in  DATA_WIDTH  received LFSR state word.
- clear  in  1  zeroes err_count and word_count; state is unaffected.
- locked  out  1  high while state is LOCKED.
- error  out  1  one-cycle pulse per mismatching word in LOCKED.
- err_count  out  CNT_WIDTH  saturating count of mismatching words while LOCKED.
- word_count  out  CNT_WIDTH  saturating count of words checked while LOCKED.

Behaviour:
- next(x) = {x[DATA_WIDTH-2:0], ^(x & POLYNOMIAL)}.
- Registers: state, expected[DATA_WIDTH], match_cnt, miss_cnt.
- States: IDLE, SYNC, LOCKED. All registers advance only on in_valid cycles, except clear and reset.
- Reset: state=IDLE, expected=0, counters=0, locked=0, error=0, err_count=0, word_count=0. Reset mid-stream drops lock immediately and overrides clear.
- IDLE:
  - in_data != 0: expected <= next(in_data), match_cnt <= 0, go to SYNC.
  - in_data == 0 is the LFSR lockup state: ignored, stay in IDLE.
- SYNC:
  - in_data == expected: match_cnt++. When match_cnt+1 == LOCK_COUNT, go to LOCKED with miss_cnt <= 0.
  - Mismatch: reseed with expected <= next(in_data), match_cnt <= 0; if in_data == 0, go to IDLE instead.
  - In both cases expected <= next(in_data).
  - No errors are counted in SYNC.
- LOCKED:
  - expected <= next(expected) (flywheel), so a corrupted word does not corrupt later predictions.
  - word_count++.
  - Match: miss_cnt <= 0.
  - Mismatch: error pulse, err_count++, miss_cnt++. When miss_cnt+1 == UNLOCK_COUNT, go to SYNC with expected <= next(in_data), match_cnt <= 0 (to IDLE if in_data == 0).
- Latency: locked, error and the counters update on the clock edge after the in_valid cycle that caused them, i.e. one cycle after the sampled word.
  - locked rises one cycle after the LOCK_COUNT-th matching word.
  - locked falls one cycle after the UNLOCK_COUNT-th consecutive mismatch.
- error is low in every cycle without an in_valid mismatch in LOCKED.
- Counters saturate at all-ones and never wrap.
- clear in the same cycle as an increment: clear wins, counter = 0 that cycle.
- in_valid low: all state holds. Gaps between words are legal at any point.

Decomposition:
- Shared package (prbs_pkg) holds:
  - the state enum (IDLE=2'd0, SYNC=2'd1, LOCKED=2'd2);
  - a lfsr_next function taking state and polynomial, used by both the generator and this checker so the taps cannot diverge.
- One natural sub-module: prbs_sat_counter (CNT_WIDTH, inc, clear, saturating), instantiated twice.
- The FSM and compare stay in the top level.

Test Plan:
- LOCKED counting, W=4, POLY=9, LOCK_COUNT=4: feed 0001,0011,0111,1111,1110 back-to-back.
  - Required: locked=1 one cycle after 1110.
  - Continuing with 1101,1010,0101 gives word_count=3, err_count=0.
- Single corruption while LOCKED: replace 1101 with 1100, then resume 1010,0101.
  - Required: one error pulse, err_count=1, locked stays 1.
  - Later words match (flywheel intact), word_count advances by 3.
- Loss of lock, UNLOCK_COUNT=3: feed 3 consecutive wrong words while LOCKED.
  - Required: err_count=3, locked falls one cycle after the third word, state=SYNC.
  - Correct stream then relocks after 4 matches.
- Zero/gaps: feed 0000 words in IDLE.
  - Required: state stays IDLE.
  - Valid stream with in_valid toggled 1,0,1,0 still locks after 5 valid words.
- Saturation/clear, CNT_WIDTH=4: force more than 15 mismatching words across relock cycles.
  - Required: err_count sticks at 4'hF.
  - clear asserted with a mismatching word gives err_count=0 and word_count=0; locked is unchanged.
- Reset mid-LOCKED: assert reset together with clear.
  - Required: next cycle all outputs 0, state=IDLE.
